// File: rtl/cache_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_pkg
// Brief    : Shared types and constants for the cache <-> memory line interface
// Revision : 1.0
// ============================================================================
package cache_mem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int BEATS_PER_LINE = 4;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_WR_BURST = 3'd3,
        ST_WR_RESP  = 3'd4
    } state_t;

    // Beats wrap inside the line: the 2-bit add drops the carry into the line index.
    function automatic logic [1:0] beat_word(input logic [1:0] start, input logic [1:0] beat);
        return start + beat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_responder_if
// Brief    : Line request / fill / writeback bundle between cache and memory
// Revision : 1.0
// ============================================================================
interface cache_mem_responder_if
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = DATA_W_DEF
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_rlast;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;
    logic              mem_wdone;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
        input  mem_req_ready, mem_rdata, mem_rvalid, mem_rlast, mem_wready, mem_wdone
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wvalid,
        output mem_req_ready, mem_rdata, mem_rvalid, mem_rlast, mem_wready, mem_wdone
    );
endinterface
`default_nettype wire

// File: rtl/mem_backing_store.sv
`default_nettype none
// ============================================================================
// Module   : mem_backing_store
// Brief    : Word store, one sync write port, one registered read port
// Revision : 1.0
// ============================================================================
module mem_backing_store #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Power-on image word i = i; reset deliberately leaves the array untouched.
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            r_mem[i] = DATA_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_responder
// Brief    : Memory-side responder for cache line fills and writebacks
// Revision : 1.0
// ============================================================================
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 4
) (
    input logic                  clk,
    input logic                  rst,
    cache_mem_responder_if.slave bus
);
    localparam logic [1:0] c_last_beat = 2'(BEATS_PER_LINE - 1);
    localparam logic [3:0] c_lat_load  = 4'(RD_LATENCY - 1);

    state_t              r_state;
    logic [ADDR_W-3:0]   r_line;
    logic [1:0]          r_start;
    logic [1:0]          r_beat;
    logic [3:0]          r_lat;
    logic                r_req_ready;
    logic                r_rvalid;
    logic                r_rlast;
    logic                r_wready;
    logic                r_wdone;

    logic                w_accept;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_rdata;

    assign w_accept = bus.mem_req && r_req_ready;
    assign w_addr   = {r_line, beat_word(r_start, r_beat)};
    assign w_wr_en  = !rst && (r_state == ST_WR_BURST) && bus.mem_wvalid;
    // The store's output register is the beat register, so fetch on the edge the beat goes out.
    assign w_rd_en  = ((r_state == ST_RD_WAIT) && (r_lat == 4'd0)) ||
                      ((r_state == ST_RD_BURST) && !r_rlast);

    mem_backing_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (w_addr),
        .i_wdata (bus.mem_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_line      <= '0;
            r_start     <= 2'd0;
            r_beat      <= 2'd0;
            r_lat       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_wready    <= 1'b0;
            r_wdone     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_line      <= bus.mem_addr[ADDR_W-1:2];
                        r_start     <= bus.mem_addr[1:0];
                        r_beat      <= 2'd0;
                        r_req_ready <= 1'b0;
                        if (bus.mem_we == OP_WRITE) begin
                            r_state  <= ST_WR_BURST;
                            r_wready <= 1'b1;
                        end else begin
                            r_state <= ST_RD_WAIT;
                            r_lat   <= c_lat_load;
                        end
                    end
                end

                ST_RD_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_state  <= ST_RD_BURST;
                        r_rvalid <= 1'b1;
                        r_beat   <= r_beat + 2'd1;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end

                ST_RD_BURST: begin
                    if (r_rlast) begin
                        r_state     <= ST_IDLE;
                        r_rvalid    <= 1'b0;
                        r_rlast     <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        // r_beat names the word being fetched now, i.e. the next beat out.
                        r_rlast <= (r_beat == c_last_beat);
                        r_beat  <= r_beat + 2'd1;
                    end
                end

                ST_WR_BURST: begin
                    if (bus.mem_wvalid) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == c_last_beat) begin
                            r_state  <= ST_WR_RESP;
                            r_wready <= 1'b0;
                            r_wdone  <= 1'b1;
                        end
                    end
                end

                ST_WR_RESP: begin
                    r_state     <= ST_IDLE;
                    r_wdone     <= 1'b0;
                    r_req_ready <= 1'b1;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rvalid    <= 1'b0;
                    r_rlast     <= 1'b0;
                    r_wready    <= 1'b0;
                    r_wdone     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_ready = r_req_ready;
    assign bus.mem_rdata     = w_rdata;
    assign bus.mem_rvalid    = r_rvalid;
    assign bus.mem_rlast     = r_rlast;
    assign bus.mem_wready    = r_wready;
    assign bus.mem_wdone     = r_wdone;
endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_responder
// Brief    : Scoreboard bench for cache_mem_responder with a word-array model
// Revision : 1.0
// ============================================================================
module tb_cache_mem_responder;
    import cache_mem_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] d;
        bit          last;
    } beat_t;

    beat_t       rd_q[$];
    int          wd_q[$];
    logic [31:0] model [1024];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          exp_ready_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid beat and every wdone pulse must match the oldest expectation.
    always @(negedge clk) begin
        beat_t e;
        if (bus.mem_rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", bus.mem_rdata, e.d);
                chk("rd_last", 32'(bus.mem_rlast), 32'(e.last));
                chk("rd_cycle", 32'(cyc), 32'(e.cyc));
                if (e.last) exp_ready_cyc = cyc + 1;
            end
        end
        if (cyc == exp_ready_cyc) begin
            chk("ready_after_rlast", 32'(bus.mem_req_ready), 32'd1);
            chk("rvalid_after_rlast", 32'(bus.mem_rvalid), 32'd0);
        end
        if (bus.mem_wdone === 1'b1) begin
            if (wd_q.size() == 0) chk("unexpected_wdone", 32'd1, 32'd0);
            else chk("wdone_cycle", 32'(cyc), 32'(wd_q.pop_front()));
        end
    end

    // Holds a request until accepted; acc is the number of the accepting edge.
    task automatic issue(input bit we, input logic [9:0] addr, output int acc);
        bus.mem_req  = 1'b1;
        bus.mem_we   = we;
        bus.mem_addr = addr;
        acc = -1;
        for (int t = 0; t < 64 && acc < 0; t++) begin
            @(negedge clk);
            if (bus.mem_req_ready === 1'b1) acc = cyc + 1;
        end
        if (acc < 0) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
    endtask

    task automatic read_line(input logic [9:0] addr, output int acc);
        int a, base, s;
        beat_t e;
        a = int'(addr);
        base = a - (a % 4);
        s = a % 4;
        issue(OP_READ, addr, acc);
        if (acc >= 0) begin
            for (int k = 0; k < 4; k++) begin
                e.cyc  = acc + LAT + k;
                e.d    = model[base + ((s + k) % 4)];
                e.last = (k == 3);
                rd_q.push_back(e);
            end
        end
    endtask

    task automatic write_line(input logic [9:0] addr, input logic [31:0] d [4],
                              input int gap_after, input int gap_len, input int nbeats);
        int a, base, s, acc;
        a = int'(addr);
        base = a - (a % 4);
        s = a % 4;
        issue(OP_WRITE, addr, acc);
        if (acc < 0) return;
        for (int k = 0; k < nbeats; k++) begin
            bus.mem_wvalid = 1'b1;
            bus.mem_wdata  = d[k];
            @(negedge clk);
            chk("wready_beat", 32'(bus.mem_wready), 32'd1);
            @(posedge clk); #1;
            model[base + ((s + k) % 4)] = d[k];
            bus.mem_wvalid = 1'b0;
            bus.mem_wdata  = $urandom;
            if (k == 3) wd_q.push_back(cyc);
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("wready_gap", 32'(bus.mem_wready), 32'd1);
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((rd_q.size() != 0 || wd_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("drain_timeout", 32'd0, 32'd1);
            rd_q.delete();
            wd_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.mem_req_ready), 32'd1);
        chk({tag, "_rvalid"},    32'(bus.mem_rvalid), 32'd0);
        chk({tag, "_rlast"},     32'(bus.mem_rlast), 32'd0);
        chk({tag, "_wready"},    32'(bus.mem_wready), 32'd0);
        chk({tag, "_wdone"},     32'(bus.mem_wdone), 32'd0);
        chk({tag, "_rdata"},     bus.mem_rdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc1, acc2, acc;
        logic [31:0] d [4];

        for (int i = 0; i < 1024; i++) model[i] = 32'(i);
        rst            = 1'b1;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        read_line(10'h010, acc); wait_done();
        read_line(10'h00E, acc); wait_done();

        d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        write_line(10'h020, d, 1, 2, 4); wait_done();

        // Stray write beats while idle must not touch the store.
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = 32'hDEADBEEF;
        repeat (3) @(posedge clk); #1;
        bus.mem_wvalid = 1'b0;
        read_line(10'h020, acc); wait_done();

        d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        write_line(10'h023, d, -1, 0, 4); wait_done();
        read_line(10'h020, acc); wait_done();

        read_line(10'h100, acc1);
        bus.mem_req  = 1'b1;
        bus.mem_we   = OP_READ;
        bus.mem_addr = 10'h104;
        @(negedge clk);
        chk("busy_ready_low", 32'(bus.mem_req_ready), 32'd0);
        @(posedge clk); #1;
        read_line(10'h104, acc2);
        chk("busy_accept_cycle", 32'(acc2), 32'(acc1 + LAT + 5));
        wait_done();

        d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        write_line(10'h040, d, -1, 0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        repeat (8) @(posedge clk); #1;
        read_line(10'h040, acc); wait_done();

        for (int n = 0; n < 24; n++) begin
            logic [9:0] ra;
            ra = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) d[k] = $urandom;
                write_line(ra, d, int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 3)), 4);
            end else begin
                read_line(ra, acc);
            end
            wait_done();
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Main-memory side of the cache line-fill/writeback interface; the responder the cache controller talks to on every miss and eviction.
- Accepts one line request at a time. For a read it returns a 4-beat fill burst after a fixed latency. For a write it absorbs a 4-beat writeback burst and pulses a completion.
- Owns the backing word store, and serves as both the synthesizable memory model and the simulation partner for the cache controller.

Parameters:
- ADDR_W, 10, word-address width; store depth is 2**ADDR_W 32-bit words.
- DATA_W, 32, beat/word width.
- RD_LATENCY, 4, cycles from request acceptance to first read beat; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  in  1  request valid; initiator holds it, with mem_we and mem_addr, stable until accepted.
- mem_we  in  1  0 = line read (fill), 1 = line write (writeback).
- mem_addr  in  ADDR_W  word address; [ADDR_W-1:2] selects the line, [1:0] selects the start (critical) word.
- mem_req_ready  out  1  high only in IDLE; acceptance = mem_req && mem_req_ready at a clock edge.
- mem_rdata  out  DATA_W  read beat data.
- mem_rvalid  out  1  read beat valid; no backpressure, initiator must sample every beat.
- mem_rlast  out  1  high with the 4th read beat.
- mem_wdata  in  DATA_W  write beat data.
- mem_wvalid  in  1  write beat valid.
- mem_wready  out  1  high only in WR_BURST.
- mem_wdone  out  1  one-cycle pulse after the 4th write beat is committed.

Behaviour:
- Reset: state IDLE, mem_req_ready=1; mem_rvalid, mem_rlast, mem_wready, mem_wdone=0; mem_rdata=0; beat and latency counters=0.
- Reset does not clear the store. At time zero, word i holds i zero-extended, set by an initial block.
- States: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_RESP.
- Request latch: on acceptance, latch the line index and the start index s=mem_addr[1:0], and clear the beat counter b.
- Beat order (reads and writes): word index = (s+b) mod 4 within the line, so beats wrap inside the line and never cross into the next line.
- IDLE -> RD_WAIT on accepted read: latency counter loads RD_LATENCY-1.
- RD_WAIT: decrement; at 0 go to RD_BURST.
- Read timing: acceptance at edge E0 gives mem_rvalid=1 from edge E(RD_LATENCY) through edge E(RD_LATENCY+3), for 4 consecutive cycles.
- RD_BURST: mem_rdata is registered from the store; mem_rlast=1 with beat 3.
- After rlast: next edge returns to IDLE, with mem_rvalid=0 and mem_req_ready=1.
- IDLE -> WR_BURST on accepted write, with mem_wready=1.
- WR_BURST: each cycle with mem_wvalid=1 writes mem_wdata to word (s+b) mod 4 and increments b. Gaps (wvalid=0) are allowed and the FSM holds.
- After the 4th beat: go to WR_RESP, mem_wready=0.
- WR_RESP: mem_wdone=1 for exactly one cycle, then IDLE.
- mem_wvalid outside WR_BURST is ignored; the store is unchanged.
- mem_req while busy: not accepted, no side effect. A new request can be accepted on the first IDLE cycle after a burst, giving one idle cycle between bursts.
- Read-after-write to the same line returns the newly written data, since the write commits before WR_RESP.
- Reset asserted mid-burst: on that edge all outputs return to reset values and the burst is abandoned.
  - Write beats already committed remain in the store.
  - No mem_wdone or mem_rlast is emitted for the aborted burst.

Decomposition:
- Package cache_mem_pkg: DATA_W default, BEATS_PER_LINE=4, OP_READ=0 / OP_WRITE=1, FSM state encodings. This package is shared with the cache controller.
- Sub-module mem_backing_store: one synchronous write port, one registered read port, initial contents word i = i.
- The responder FSM and counters stay in the top module.

Test Plan:
- Read line: after reset, read at addr 0x010 with RD_LATENCY=4 -> rvalid beats 4..7 cycles after acceptance with data 0x10, 0x11, 0x12, 0x13; rlast on 0x13; req_ready back high the next cycle.
- Critical-word wrap: read at addr 0x00E -> beats 0x0E, 0x0F, 0x0C, 0x0D.
- Write then read back: write at addr 0x020 with beats 0xA0..0xA3, wvalid dropped for 2 cycles after beat 1 -> wready held, one wdone pulse. A following read of 0x020 returns 0xA0, 0xA1, 0xA2, 0xA3.
- Wrapped write: write at 0x023 with 0xB0..0xB3 -> words 0x23=0xB0, 0x20=0xB1, 0x21=0xB2, 0x22=0xB3, verified by reading 0x020.
- Busy rejection: assert a second req during RD_WAIT -> req_ready=0 and the request is not accepted until the cycle after rlast. The second read then completes normally.
- Reset mid-write: rst after 2 of 4 beats at 0x040 (data 0xC0, 0xC1) -> no wdone, all outputs at reset values. A read of 0x040 returns 0xC0, 0xC1, 0x42, 0x43.
